// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, instruction-cache address view and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default icache geometry (16 frames); icachef_t describes that split.
  localparam int unsigned ICACHE_IDX_W = 4;
  localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icstate_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits are combinational in IDLE; a miss latches the address and fetches it
// from the memory controller, filling the frame when iwait drops.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IW = $clog2(NSETS);
  localparam int unsigned TW = 30 - IW;

  logic [NSETS-1:0] valid;
  logic [TW-1:0]    tags [NSETS];
  word_t            data [NSETS];

  icstate_t state;
  word_t    missaddr;

  logic [IW-1:0] idx, midx;
  logic [TW-1:0] tag, mtag;
  logic          fill;

  assign idx  = imemaddr[IW+1:2];
  assign tag  = imemaddr[31:IW+2];
  assign midx = missaddr[IW+1:2];
  assign mtag = missaddr[31:IW+2];
  assign fill = (state == FETCH) && !iwait;

  // Hit detection and datapath/memory-side outputs
  always_comb begin
    ihit     = (state == IDLE) && imemREN && valid[idx] && (tags[idx] == tag);
    imemload = ihit ? data[idx] : '0;
    iREN     = (state == FETCH);
    iaddr    = iREN ? missaddr : '0;
  end

  // FSM, valid bits and miss-address register (async active-low reset)
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      valid    <= '0;
      missaddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !ihit) begin
            missaddr <= imemaddr;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid[midx] <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame tag/data storage; only valid bits need reset
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[midx] <= mtag;
      data[midx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (NSETS=16) with an expected-output scoreboard.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  icache #(.NSETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string t, input logic h, input logic [31:0] l,
                      input logic r, input logic [31:0] a);
    exp_t e;
    e.tag = t; e.hit = h; e.load = l; e.ren = r; e.addr = a;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (ihit === e.hit) else begin
      failures++;
      $error("FAIL %s.ihit observed=%b expected=%b", e.tag, ihit, e.hit);
    end
    checks++;
    assert (imemload === e.load) else begin
      failures++;
      $error("FAIL %s.imemload observed=%h expected=%h", e.tag, imemload, e.load);
    end
    checks++;
    assert (iREN === e.ren) else begin
      failures++;
      $error("FAIL %s.iREN observed=%b expected=%b", e.tag, iREN, e.ren);
    end
    checks++;
    assert (iaddr === e.addr) else begin
      failures++;
      $error("FAIL %s.iaddr observed=%h expected=%h", e.tag, iaddr, e.addr);
    end
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    #12;
    push("reset", 1'b0, 32'h0, 1'b0, 32'h0); check();
    @(negedge CLK); nRST = 1'b1;
    cyc();

    // Cold miss on 0x0 with three wait cycles
    imemREN = 1'b1; imemaddr = 32'h0;
    push("miss0_req", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    push("miss0_fetch1", 1'b0, 32'h0, 1'b1, 32'h0); check();
    cyc();
    push("miss0_fetch2", 1'b0, 32'h0, 1'b1, 32'h0); check();
    cyc();
    push("miss0_fetch3", 1'b0, 32'h0, 1'b1, 32'h0); check();
    iwait = 1'b0; iload = 32'h2001_0005;
    push("miss0_fill", 1'b0, 32'h0, 1'b1, 32'h0); check();
    cyc();
    iwait = 1'b1; iload = '0;
    push("miss0_hit", 1'b1, 32'h2001_0005, 1'b0, 32'h0); check();
    cyc();
    push("repeat_hit", 1'b1, 32'h2001_0005, 1'b0, 32'h0); check();

    // Conflict: 0x40 shares the frame with 0x0
    imemaddr = 32'h40;
    push("conf40_req", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    iwait = 1'b0; iload = 32'h1111_1111;
    push("conf40_fetch", 1'b0, 32'h0, 1'b1, 32'h40); check();
    cyc();
    iwait = 1'b1;
    push("conf40_hit", 1'b1, 32'h1111_1111, 1'b0, 32'h0); check();
    imemaddr = 32'h0;
    push("evicted0_miss", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    iwait = 1'b0; iload = 32'h2001_0005;
    push("refill0_fetch", 1'b0, 32'h0, 1'b1, 32'h0); check();
    cyc();
    iwait = 1'b1;
    push("refill0_hit", 1'b1, 32'h2001_0005, 1'b0, 32'h0); check();

    // Address change during FETCH must not redirect the fill
    imemaddr = 32'h4;
    push("miss4_req", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    imemaddr = 32'h8; iwait = 1'b0; iload = 32'hDEAD_BEEF;
    push("miss4_fetch_addrchg", 1'b0, 32'h0, 1'b1, 32'h4); check();
    cyc();
    iwait = 1'b1; imemREN = 1'b0;
    push("idle_ren_low", 1'b0, 32'h0, 1'b0, 32'h0); check();
    imemREN = 1'b1;
    push("addr8_miss", 1'b0, 32'h0, 1'b0, 32'h0); check();
    imemaddr = 32'h4;
    push("addr4_hit", 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0); check();
    imemaddr = 32'h404;
    push("addr404_same_idx_miss", 1'b0, 32'h0, 1'b0, 32'h0); check();
    imemaddr = 32'h4;
    cyc();

    // Reset in the middle of a fetch
    imemaddr = 32'h10;
    push("miss10_req", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    imemREN = 1'b0;
    push("miss10_fetch_renlow", 1'b0, 32'h0, 1'b1, 32'h10); check();
    nRST = 1'b0;
    push("async_reset_fetch", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    push("in_reset", 1'b0, 32'h0, 1'b0, 32'h0); check();
    @(negedge CLK); nRST = 1'b1;
    cyc();
    imemREN = 1'b1; imemaddr = 32'h0;
    push("post_reset_0_miss", 1'b0, 32'h0, 1'b0, 32'h0); check();
    cyc();
    push("post_reset_0_fetch", 1'b0, 32'h0, 1'b1, 32'h0); check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
